// File: rtl/bus_pkg.sv
// Shared bus types: packet kinds, identifiers, addresses and payloads used by
// requesters and responders on the memory bus.
package bus_pkg;

  typedef logic [3:0]  BusID;
  typedef logic [31:0] memory_address_t;
  typedef logic [63:0] bus_packet_payload_t;

  typedef enum logic [1:0] {
    bus_read_data     = 2'd0,
    bus_write_data    = 2'd1,
    bus_read_response = 2'd2
  } bus_kind_t;

  typedef struct packed {
    bus_kind_t           kind;
    BusID                source;
    memory_address_t     address;
    bus_packet_payload_t payload;
  } BusPacket;

endpackage

// File: rtl/memory_bus_ram.sv
// Single-port payload storage: synchronous write, combinational read.
// Contents are intentionally never reset.
module memory_bus_ram
  import bus_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  bus_packet_payload_t wdata,
  output bus_packet_payload_t rdata
);

  bus_packet_payload_t mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_bus_responder.sv
// Memory bus responder: accepts read/write packets, serves reads after
// READ_LATENCY cycles. Define MEMORY_BUS_RESPONDER_STATS_EN for rd/wr counters.
module memory_bus_responder
  import bus_pkg::*;
#(
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_busy,
  input  BusPacket    req_pkt,
  output logic        req_accept,
  input  logic        resp_busy,
  output logic        resp_send,
  output BusPacket    resp_pkt,
  output logic        err_addr,
  output logic        err_proto
`ifdef MEMORY_BUS_RESPONDER_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t              state_q, state_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  BusID                src_q;
  logic [AW-1:0]       addr_q;
  logic                addr_ok_q;
  logic                err_addr_q, err_proto_q;

  logic                is_rd, is_wr, is_proto, req_in_range;
  logic                ram_we;
  logic [AW-1:0]       ram_addr;
  bus_packet_payload_t ram_rdata;

  assign is_rd        = (req_pkt.kind == bus_read_data);
  assign is_wr        = (req_pkt.kind == bus_write_data);
  assign is_proto     = !(is_rd || is_wr);
  assign req_in_range = (req_pkt.address < memory_address_t'(MEM_WORDS));

  // Handshake pulses are gated by reset_n so they drop the instant reset asserts.
  assign req_accept = reset_n && (state_q == IDLE) && req_busy;
  assign resp_send  = reset_n && (state_q == RESPOND) && !resp_busy;

  // The RAM port serves the incoming write while idle and the latched read address otherwise,
  // so a read accepted right after a write sees the freshly written word.
  assign ram_we   = req_accept && is_wr && req_in_range;
  assign ram_addr = (state_q == IDLE) ? req_pkt.address[AW-1:0] : addr_q;

  memory_bus_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_pkt.payload),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_accept && is_rd) begin
          lat_cnt_d = 4'(READ_LATENCY - 1);
          state_d   = (READ_LATENCY == 1) ? RESPOND : ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt_q <= 4'd1) begin
          lat_cnt_d = '0;
          state_d   = RESPOND;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESPOND: begin
        if (resp_send) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      addr_ok_q   <= 1'b0;
      err_addr_q  <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      if (req_accept) begin
        if (is_proto)           err_proto_q <= 1'b1;
        else if (!req_in_range) err_addr_q  <= 1'b1;
        if (is_rd)              addr_ok_q   <= req_in_range;
      end
    end
  end

  // Read context: data-only registers, meaningful only while a read is pending.
  always_ff @(posedge clk) begin
    if (req_accept && is_rd) begin
      src_q  <= req_pkt.source;
      addr_q <= req_pkt.address[AW-1:0];
    end
  end

  always_comb begin
    resp_pkt = '0;
    if (resp_send) begin
      resp_pkt.kind    = bus_read_response;
      resp_pkt.source  = src_q;
      resp_pkt.address = '0;
      resp_pkt.payload = addr_ok_q ? ram_rdata : '0;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_proto = err_proto_q;

`ifdef MEMORY_BUS_RESPONDER_STATS_EN
  logic [31:0] rd_count_q, wr_count_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (req_accept) begin
      if (is_rd) rd_count_q <= sat_inc(rd_count_q);
      if (is_wr) wr_count_q <= sat_inc(wr_count_q);
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed bench for memory_bus_responder (default MEM_WORDS=1024, READ_LATENCY=2);
// stats checks are compiled in with MEMORY_BUS_RESPONDER_STATS_EN.
module tb_memory_bus_responder;
  import bus_pkg::*;

  logic     clk = 1'b0;
  logic     reset_n;
  logic     req_busy;
  BusPacket req_pkt;
  logic     req_accept;
  logic     resp_busy;
  logic     resp_send;
  BusPacket resp_pkt;
  logic     err_addr;
  logic     err_proto;
`ifdef MEMORY_BUS_RESPONDER_STATS_EN
  logic [31:0] rd_count, wr_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  BusPacket exp_pkt;

  memory_bus_responder #(
    .MEM_WORDS    (1024),
    .READ_LATENCY (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_busy   (req_busy),
    .req_pkt    (req_pkt),
    .req_accept (req_accept),
    .resp_busy  (resp_busy),
    .resp_send  (resp_send),
    .resp_pkt   (resp_pkt),
    .err_addr   (err_addr),
    .err_proto  (err_proto)
`ifdef MEMORY_BUS_RESPONDER_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input BusPacket obs, input BusPacket exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bus_kind_t k, input logic [3:0] src,
                       input logic [31:0] a, input logic [63:0] p);
    req_busy        = 1'b1;
    req_pkt.kind    = k;
    req_pkt.source  = src;
    req_pkt.address = a;
    req_pkt.payload = p;
  endtask

  task automatic resp_exp(input logic [3:0] src, input logic [63:0] p);
    exp_pkt.kind    = bus_read_response;
    exp_pkt.source  = src;
    exp_pkt.address = 32'h0;
    exp_pkt.payload = p;
  endtask

  initial begin
    reset_n   = 1'b0;
    resp_busy = 1'b0;
    drive(bus_read_data, 4'h1, 32'h5, 64'h0);
    #2;
    chk1("rst_req_accept", req_accept, 1'b0);
    chk1("rst_resp_send", resp_send, 1'b0);
    chk_pkt("rst_resp_pkt", resp_pkt, '0);
    chk1("rst_err_addr", err_addr, 1'b0);
    chk1("rst_err_proto", err_proto, 1'b0);
    req_busy = 1'b0;
    #10 reset_n = 1'b1;
    tick();

    // write addr 5, then read it back on the very next cycle
    drive(bus_write_data, 4'h1, 32'h5, 64'hDEAD_BEEF);
    #1 chk1("wr_accept", req_accept, 1'b1);
    tick();
    drive(bus_read_data, 4'h3, 32'h5, 64'h0);
    #1 chk1("wr_no_resp", resp_send, 1'b0);
    chk1("rd_accept", req_accept, 1'b1);
    tick();
    req_busy = 1'b0;
    #1 chk1("rd_access_no_resp", resp_send, 1'b0);
    tick();
    resp_exp(4'h3, 64'hDEAD_BEEF);
    chk1("rd_resp_send", resp_send, 1'b1);
    chk_pkt("rd_resp_pkt", resp_pkt, exp_pkt);
    tick();
    chk1("rd_resp_single", resp_send, 1'b0);
    chk_pkt("rd_resp_pkt_zero", resp_pkt, '0);

    // backpressure: response held for 10 cycles, pending write ignored
    resp_busy = 1'b1;
    drive(bus_read_data, 4'h7, 32'h5, 64'h0);
    #1 chk1("bp_rd_accept", req_accept, 1'b1);
    tick();
    req_busy = 1'b0;
    tick();
    drive(bus_write_data, 4'h2, 32'h5, 64'h1111);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1("bp_no_send", resp_send, 1'b0);
      chk1("bp_no_accept", req_accept, 1'b0);
      chk_pkt("bp_pkt_zero", resp_pkt, '0);
      tick();
    end
    req_busy  = 1'b0;
    resp_busy = 1'b0;
    #1;
    resp_exp(4'h7, 64'hDEAD_BEEF);
    chk1("bp_release_send", resp_send, 1'b1);
    chk_pkt("bp_release_pkt", resp_pkt, exp_pkt);
    tick();
    chk1("bp_single_send", resp_send, 1'b0);

    // range: last valid word, then out-of-range read and writes
    drive(bus_write_data, 4'h1, 32'd1023, 64'hA5A5);
    tick();
    req_busy = 1'b0;
    #1 chk1("range_last_no_err", err_addr, 1'b0);
    drive(bus_read_data, 4'h2, 32'd1024, 64'h0);
    tick();
    req_busy = 1'b0;
    #1 chk1("range_err_addr", err_addr, 1'b1);
    tick();
    resp_exp(4'h2, 64'h0);
    chk1("range_rd_send", resp_send, 1'b1);
    chk_pkt("range_rd_pkt", resp_pkt, exp_pkt);
    tick();
    drive(bus_write_data, 4'h1, 32'hFFFF_FFFF, 64'h5555);
    tick();
    drive(bus_write_data, 4'h1, 32'h405, 64'h6666);
    tick();
    drive(bus_read_data, 4'h4, 32'd1023, 64'h0);
    tick();
    req_busy = 1'b0;
    tick();
    resp_exp(4'h4, 64'hA5A5);
    chk1("range_last_send", resp_send, 1'b1);
    chk_pkt("range_last_unchanged", resp_pkt, exp_pkt);
    tick();
    drive(bus_read_data, 4'h5, 32'h5, 64'h0);
    tick();
    req_busy = 1'b0;
    tick();
    resp_exp(4'h5, 64'hDEAD_BEEF);
    chk_pkt("range_alias_unchanged", resp_pkt, exp_pkt);
    tick();

    // protocol error
    chk1("proto_err_before", err_proto, 1'b0);
    drive(bus_read_response, 4'h9, 32'h5, 64'h77);
    #1 chk1("proto_accept", req_accept, 1'b1);
    tick();
    req_busy = 1'b0;
    #1 chk1("proto_err_set", err_proto, 1'b1);
    chk1("proto_no_resp0", resp_send, 1'b0);
    tick();
    chk1("proto_no_resp1", resp_send, 1'b0);
    tick();
    chk1("proto_no_resp2", resp_send, 1'b0);

    // reset during ACCESS abandons the read and keeps memory
    drive(bus_read_data, 4'h4, 32'h5, 64'h0);
    tick();
    drive(bus_read_data, 4'h4, 32'h5, 64'h0);
    #1 reset_n = 1'b0;
    #1;
    chk1("mid_rst_accept", req_accept, 1'b0);
    chk1("mid_rst_send", resp_send, 1'b0);
    chk_pkt("mid_rst_pkt", resp_pkt, '0);
    chk1("mid_rst_err_addr", err_addr, 1'b0);
    chk1("mid_rst_err_proto", err_proto, 1'b0);
    req_busy = 1'b0;
    #3 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("post_rst_no_resp", resp_send, 1'b0);
    end
    drive(bus_read_data, 4'h6, 32'h5, 64'h0);
    #1 chk1("post_rst_accept", req_accept, 1'b1);
    tick();
    req_busy = 1'b0;
    tick();
    resp_exp(4'h6, 64'hDEAD_BEEF);
    chk1("post_rst_send", resp_send, 1'b1);
    chk_pkt("post_rst_mem_kept", resp_pkt, exp_pkt);
    tick();

`ifdef MEMORY_BUS_RESPONDER_STATS_EN
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(bus_write_data, 4'h1, 32'(10 + i), 64'(i));
      tick();
    end
    req_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(bus_read_data, 4'h1, 32'(10 + i), 64'h0);
      tick();
      req_busy = 1'b0;
      tick();
      tick();
    end
    drive(bus_read_response, 4'h1, 32'h0, 64'h0);
    tick();
    req_busy = 1'b0;
    #1;
    vectors++;
    assert (wr_count === 32'd3) else begin
      miscompares++;
      $error("FAIL stats_wr_count observed=%0d expected=3", wr_count);
    end
    vectors++;
    assert (rd_count === 32'd2) else begin
      miscompares++;
      $error("FAIL stats_rd_count observed=%0d expected=2", rd_count);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
